// File: rtl/image_window_buffer.sv
// image_window_buffer: frame store loaded from a valid/ready stream and replayed as KxK windows.
// Define IMAGE_WINDOW_BUFFER_ZERO_PAD_EN to add (K-1)/2 zero padding around the frame.
//
// state | meaning
// LOAD  | accepting frame pixels in raster order, s_ready=1
// FULL  | frame resident, waiting for start
// SCAN  | issuing window pixel reads and streaming them out
// DONE  | one-cycle done pulse, then back to LOAD at address 0
module image_window_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      full,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_last,
  output logic                      m_wlast,
  input  logic [$clog2(IMG_H)-1:0]  rd_row,
  input  logic [$clog2(IMG_W)-1:0]  rd_col,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int N  = IMG_W * IMG_H;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(IMG_W + IMG_H + 2 * K) + 2;
`ifdef IMAGE_WINDOW_BUFFER_ZERO_PAD_EN
  localparam int P = (K - 1) / 2;
`else
  localparam int P = 0;
`endif
  localparam int NWX = (IMG_W + 2 * P - K) / STRIDE + 1;
  localparam int NWY = (IMG_H + 2 * P - K) / STRIDE + 1;
  localparam logic signed [CW-1:0] ORG0   = CW'(-P);
  localparam logic signed [CW-1:0] OX_END = CW'((NWX - 1) * STRIDE - P);
  localparam logic signed [CW-1:0] OY_END = CW'((NWY - 1) * STRIDE - P);
  localparam logic signed [CW-1:0] K_END  = CW'(K - 1);
  localparam logic signed [CW-1:0] STEP   = CW'(STRIDE);
  localparam logic signed [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {LOAD, FULL, SCAN, DONE} state_t;
  state_t state;

  logic [DATA_W-1:0]    mem [N];
  logic [AW-1:0]        waddr;
  logic signed [CW-1:0] kx, ky, ox, oy;
  logic                 gen;
  logic                 rd_v, rd_pad, rd_last, rd_wlast;
  logic [DATA_W-1:0]    ram_q;
  logic                 tail_v, tail_last, tail_wlast;
  logic [DATA_W-1:0]    tail_data;

  logic                 load_hs, pop, push, issue, credit, oob, k_wrap, win_end;
  logic signed [CW-1:0] px, py;
  logic [AW-1:0]        raddr, rd_addr;
  logic [1:0]           occ;
  logic [DATA_W-1:0]    push_data;

  assign load_hs   = s_valid & s_ready;
  assign pop       = m_valid & m_ready;
  assign push      = rd_v;
  // Output slots = head + skid + the read in flight; issue only if the next push is guaranteed a slot.
  assign occ       = 2'(m_valid) + 2'(tail_v) + 2'(rd_v);
  assign credit    = (occ < 2'd2) | (pop & (occ == 2'd2));
  assign issue     = (state == SCAN) & gen & credit;
  assign px        = ox + kx;
  assign py        = oy + ky;
  assign raddr     = AW'(32'(py) * IMG_W + 32'(px));
  assign rd_addr   = AW'(32'(rd_row) * IMG_W + 32'(rd_col));
  assign k_wrap    = (kx == K_END) & (ky == K_END);
  assign win_end   = k_wrap & (ox == OX_END) & (oy == OY_END);
  assign push_data = rd_pad ? '0 : ram_q;

`ifdef IMAGE_WINDOW_BUFFER_ZERO_PAD_EN
  assign oob = px[CW-1] | (px >= CW'(IMG_W)) | py[CW-1] | (py >= CW'(IMG_H));
`else
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (load_hs) mem[waddr] <= s_data;
    if (issue && !oob) ram_q <= mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD;
      s_ready <= 1'b1;
      full    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      waddr   <= '0;
      gen     <= 1'b0;
      kx      <= '0;
      ky      <= '0;
      ox      <= '0;
      oy      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: if (load_hs) begin
          if (waddr == AW'(N - 1)) begin
            waddr   <= '0;
            state   <= FULL;
            s_ready <= 1'b0;
            full    <= 1'b1;
          end else begin
            waddr <= waddr + AW'(1);
          end
        end
        FULL: if (start) begin
          state <= SCAN;
          full  <= 1'b0;
          busy  <= 1'b1;
          gen   <= 1'b1;
          kx    <= '0;
          ky    <= '0;
          ox    <= ORG0;
          oy    <= ORG0;
        end
        SCAN: begin
          if (issue) begin
            kx <= (kx == K_END) ? '0 : kx + ONE;
            if (kx == K_END) begin
              ky <= (ky == K_END) ? '0 : ky + ONE;
              if (ky == K_END) begin
                ox <= (ox == OX_END) ? ORG0 : ox + STEP;
                if (ox == OX_END) oy <= oy + STEP;
              end
            end
            if (win_end) gen <= 1'b0;
          end
          if (pop && m_wlast) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state   <= LOAD;
          s_ready <= 1'b1;
          waddr   <= '0;
        end
        default: state <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v       <= 1'b0;
      rd_pad     <= 1'b0;
      rd_last    <= 1'b0;
      rd_wlast   <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      m_wlast    <= 1'b0;
      tail_v     <= 1'b0;
      tail_data  <= '0;
      tail_last  <= 1'b0;
      tail_wlast <= 1'b0;
      rd_data    <= '0;
    end else begin
      rd_v    <= issue;
      rd_data <= mem[rd_addr];
      if (issue) begin
        rd_pad   <= oob;
        rd_last  <= k_wrap;
        rd_wlast <= win_end;
      end
      if (pop || !m_valid) begin
        if (tail_v) begin
          m_valid <= 1'b1;
          m_data  <= tail_data;
          m_last  <= tail_last;
          m_wlast <= tail_wlast;
          tail_v  <= push;
          if (push) begin
            tail_data  <= push_data;
            tail_last  <= rd_last;
            tail_wlast <= rd_wlast;
          end
        end else begin
          m_valid <= push;
          if (push) begin
            m_data  <= push_data;
            m_last  <= rd_last;
            m_wlast <= rd_wlast;
          end
        end
      end else if (push) begin
        tail_v     <= 1'b1;
        tail_data  <= push_data;
        tail_last  <= rd_last;
        tail_wlast <= rd_wlast;
      end
    end
  end

endmodule

// File: tb/tb_image_window_buffer.sv
// tb_image_window_buffer: scoreboard bench, stride-1 (a) and stride-2 (b) instances fed identically.
// Defining IMAGE_WINDOW_BUFFER_ZERO_PAD_EN switches the reference model to padded windows.
`timescale 1ns/1ps
module tb_image_window_buffer;

  localparam int DW   = 8;
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int K    = 3;
  localparam int NPIX = W * H;
`ifdef IMAGE_WINDOW_BUFFER_ZERO_PAD_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NW1 = (W + 2 * P - K) / 1 + 1;
  localparam int NW2 = (W + 2 * P - K) / 2 + 1;
  localparam int PW  = DW + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic start = 1'b0;
  logic m_ready = 1'b0;
  logic [2:0] rd_row = '0;
  logic [2:0] rd_col = '0;

  logic s_ready_a, full_a, busy_a, done_a, m_valid_a, m_last_a, m_wlast_a;
  logic [DW-1:0] m_data_a, rd_data_a;
  logic s_ready_b, full_b, busy_b, done_b, m_valid_b, m_last_b, m_wlast_b;
  logic [DW-1:0] m_data_b, rd_data_b;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] q_a[$];
  logic [PW-1:0] q_b[$];
  logic [DW-1:0] cap_a[$];
  logic [DW-1:0] cap_b[$];
  logic [DW-1:0] prev_a[$];
  int hs_a, hs_b;
  bit pend_a, pend_b, seen_a, seen_b, stall_a, stall_b;
  logic [PW-1:0] held_a, held_b;
  int w0[9];
  int wl[9];
  int w1s2[9];

  image_window_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(K), .STRIDE(1)) u_dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
    .full(full_a), .start(start), .busy(busy_a), .done(done_a), .m_valid(m_valid_a),
    .m_ready(m_ready), .m_data(m_data_a), .m_last(m_last_a), .m_wlast(m_wlast_a),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data_a)
  );

  image_window_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(K), .STRIDE(2)) u_dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .full(full_b), .start(start), .busy(busy_b), .done(done_b), .m_valid(m_valid_b),
    .m_ready(m_ready), .m_data(m_data_b), .m_last(m_last_b), .m_wlast(m_wlast_b),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int d, input int s, input int base);
    int nw, x, y;
    logic [DW-1:0] v;
    bit l, wl_f;
    nw = (W + 2 * P - K) / s + 1;
    for (int wy = 0; wy < nw; wy++)
      for (int wx = 0; wx < nw; wx++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            y = wy * s - P + ky;
            x = wx * s - P + kx;
            v = (y >= 0 && y < H && x >= 0 && x < W) ? DW'(base + y * W + x) : '0;
            l = (ky == K - 1) && (kx == K - 1);
            wl_f = l && (wy == nw - 1) && (wx == nw - 1);
            if (d == 0) q_a.push_back({v, l, wl_f});
            else        q_b.push_back({v, l, wl_f});
          end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      pend_a = 1'b0;
      stall_a = 1'b0;
    end else begin
      if (pend_a || done_a) begin
        chk("done_a", done_a, pend_a);
        if (pend_a) chk("busy_at_done_a", busy_a, 0);
        if (done_a) seen_a = 1'b1;
      end
      if (stall_a) chk("hold_a", {m_valid_a, m_data_a, m_last_a, m_wlast_a}, {1'b1, held_a});
      pend_a = 1'b0;
      if (m_valid_a && m_ready) begin
        chk("expect_pending_a", q_a.size() > 0, 1);
        if (q_a.size() > 0) chk("pix_a", {m_data_a, m_last_a, m_wlast_a}, q_a.pop_front());
        cap_a.push_back(m_data_a);
        hs_a++;
        pend_a = m_wlast_a;
      end
      stall_a = m_valid_a && !m_ready;
      held_a = {m_data_a, m_last_a, m_wlast_a};
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pend_b = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (pend_b || done_b) begin
        chk("done_b", done_b, pend_b);
        if (pend_b) chk("busy_at_done_b", busy_b, 0);
        if (done_b) seen_b = 1'b1;
      end
      if (stall_b) chk("hold_b", {m_valid_b, m_data_b, m_last_b, m_wlast_b}, {1'b1, held_b});
      pend_b = 1'b0;
      if (m_valid_b && m_ready) begin
        chk("expect_pending_b", q_b.size() > 0, 1);
        if (q_b.size() > 0) chk("pix_b", {m_data_b, m_last_b, m_wlast_b}, q_b.pop_front());
        cap_b.push_back(m_data_b);
        hs_b++;
        pend_b = m_wlast_b;
      end
      stall_b = m_valid_b && !m_ready;
      held_b = {m_data_b, m_last_b, m_wlast_b};
    end
  end

  task automatic chk_reset();
    chk("rst_s_ready", s_ready_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_m_data", m_data_a, 0);
    chk("rst_m_last", m_last_a, 0);
    chk("rst_m_wlast", m_wlast_a, 0);
    chk("rst_rd_data", rd_data_a, 0);
    chk("rst_m_valid_b", m_valid_b, 0);
  endtask

  task automatic load_frame(input int base);
    for (int i = 0; i < NPIX; i++) begin
      s_valid = 1'b0;
      while ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data = DW'(base + i);
      if (i == NPIX - 1) begin
        chk("full_before_last", full_a, 0);
        chk("s_ready_last", s_ready_a, 1);
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    chk("full_a", full_a, 1);
    chk("full_b", full_b, 1);
    chk("s_ready_full", s_ready_a, 0);
  endtask

  task automatic rd_sweep(input int base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        rd_row = 3'(r);
        rd_col = 3'(c);
        @(posedge clk);
        #1;
        chk("rd_sweep", rd_data_a, DW'(base + r * W + c));
      end
    rd_row = 3'd2;
    rd_col = 3'd3;
    @(posedge clk);
    #1;
    chk("rd_2_3", rd_data_b, DW'(base + 13));
  endtask

  task automatic run_scan(input int base, input bit rnd, input int stop_at);
    q_a.delete();
    q_b.delete();
    model(0, 1, base);
    model(1, 2, base);
    cap_a.delete();
    cap_b.delete();
    hs_a = 0;
    hs_b = 0;
    seen_a = 1'b0;
    seen_b = 1'b0;
    m_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_start", busy_a, 1);
    chk("mv_lat0", m_valid_a, 0);
    @(posedge clk);
    #1;
    chk("mv_lat1", m_valid_a, 0);
    @(posedge clk);
    #1;
    chk("mv_lat2", m_valid_a, 1);
    for (int n = 0; n < 3000; n++) begin
      if (stop_at > 0 && hs_a >= stop_at) break;
      if (seen_a && seen_b) break;
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    if (stop_at > 0) begin
      chk("reached_stop", hs_a >= stop_at, 1);
    end else begin
      chk("scan_end", seen_a && seen_b, 1);
      chk("s_ready_after", s_ready_a, 1);
      chk("busy_after", busy_a, 0);
      chk("count_a", cap_a.size(), NW1 * NW1 * K * K);
      chk("count_b", cap_b.size(), NW2 * NW2 * K * K);
      chk("q_empty_a", q_a.size(), 0);
      chk("q_empty_b", q_b.size(), 0);
      repeat (4) begin
        @(posedge clk);
        #1;
      end
      chk("start_held_busy", busy_a, 0);
      chk("start_held_mv", m_valid_a, 0);
      start = 1'b0;
    end
  endtask

  initial begin
    int diff;
`ifdef IMAGE_WINDOW_BUFFER_ZERO_PAD_EN
    w0   = '{0, 0, 0, 0, 0, 1, 0, 5, 6};
    wl   = '{18, 19, 0, 23, 24, 0, 0, 0, 0};
    w1s2 = '{0, 0, 0, 1, 2, 3, 6, 7, 8};
`else
    w0   = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    wl   = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    w1s2 = '{2, 3, 4, 7, 8, 9, 12, 13, 14};
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;

    load_frame(0);
    s_valid = 1'b1;
    s_data = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("full_hold", full_a, 1);
    rd_sweep(0);

    run_scan(0, 1'b0, 0);
    if (cap_a.size() >= 9) begin
      for (int i = 0; i < 9; i++) begin
        chk("win_first", cap_a[i], w0[i]);
        chk("win_last", cap_a[cap_a.size() - 9 + i], wl[i]);
      end
    end
    if (cap_b.size() >= 18) begin
      for (int i = 0; i < 9; i++) chk("s2_win1", cap_b[9 + i], w1s2[i]);
    end
    prev_a = cap_a;

    load_frame(0);
    run_scan(0, 1'b1, 0);
    chk("stream_len", cap_a.size(), prev_a.size());
    diff = 0;
    for (int i = 0; i < prev_a.size() && i < cap_a.size(); i++)
      if (cap_a[i] !== prev_a[i]) diff++;
    chk("stream_eq", diff, 0);

    load_frame(0);
    run_scan(0, 1'b0, 40);
    rst = 1'b1;
    #1;
    chk_reset();
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    @(posedge clk);
    #1;
    chk("s_ready_post_rst", s_ready_a, 1);

    load_frame(50);
    rd_sweep(50);
    run_scan(50, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
